// File: rtl/react_pkg.sv
// Shared definitions for the reaction-time sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: FSM state encoding, oScreen codes, LFSR seed/taps and helpers.
package react_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ARMED       = 3'd1,
    GO          = 3'd2,
    RESULT      = 3'd3,
    FALSE_START = 3'd4
  } state_t;

  localparam logic [2:0] SCR_IDLE   = 3'd0;
  localparam logic [2:0] SCR_RED    = 3'd1;
  localparam logic [2:0] SCR_GREEN  = 3'd2;
  localparam logic [2:0] SCR_RESULT = 3'd3;
  localparam logic [2:0] SCR_SOON   = 3'd4;

  // Right-shifting Fibonacci LFSR: polynomial taps 16,14,13,11 sit on
  // register bits 0,2,3,5; the feedback enters at bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  function automatic logic [2:0] screen_of(input state_t s);
    logic [2:0] code;
    code = SCR_IDLE;
    case (s)
      IDLE:        code = SCR_IDLE;
      ARMED:       code = SCR_RED;
      GO:          code = SCR_GREEN;
      RESULT:      code = SCR_RESULT;
      FALSE_START: code = SCR_SOON;
      default:     code = SCR_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler: counts 0..DIV-1, oTick high on the terminal count.
// Latency: first tick DIV cycles after the edge that samples iClear high.
// Backpressure: none; free-running, iClear restarts the count.
// Ports: clk, iResetn (async active-low), iClear (restart), oTick (1-cycle pulse).
module ms_tick_gen #(
  parameter int unsigned DIV = 50_000
) (
  input  logic clk,
  input  logic iResetn,
  input  logic iClear,
  output logic oTick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign oTick = (cnt == TERM);

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      cnt <= '0;
    end else if (iClear || oTick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/react_controller.sv
// Reaction-time round sequencer: random red delay, green ms timer, false-start and best time.
// Latency: all outputs registered; result appears 1 cycle after the hit is sampled.
// Backpressure: none; iEnable low forces IDLE. Optional macro REACT_CTRL_BEST_EN adds best-time tracking.
// Ports: clk, iResetn, iEnable, iHit in; oScreen, oTimeMs, oValid, oTimeout, oBestMs out.
module react_controller
  import react_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 12,
  parameter int unsigned TIMEOUT_MS   = 9999
) (
  input  logic        clk,
  input  logic        iResetn,
  input  logic        iEnable,
  input  logic        iHit,
  output logic [2:0]  oScreen,
  output logic [13:0] oTimeMs,
  output logic        oValid,
  output logic        oTimeout,
  output logic [13:0] oBestMs
);

  // Wide enough for the largest delay MIN_DELAY_MS + 2^RAND_BITS - 1.
  localparam int DLY_W = $clog2(MIN_DELAY_MS + (2 ** RAND_BITS));
  localparam logic [13:0] TO14 = 14'(TIMEOUT_MS);

  state_t             state, state_n;
  logic               hit_prev, hit_edge;
  logic [15:0]        lfsr;
  logic [DLY_W-1:0]   delay_cnt;
  logic [13:0]        time_cnt, time_next;
  logic               tick, clr;
  logic               load_delay, latch_hit, latch_to;

  assign hit_edge = iHit & ~hit_prev;

  ms_tick_gen #(.DIV(CLK_HZ / 1000)) u_tick (
    .clk     (clk),
    .iResetn (iResetn),
    .iClear  (clr),
    .oTick   (tick)
  );

  // Elapsed ms including this cycle's tick, saturating at the limit. A hit on
  // the timeout tick therefore latches TIMEOUT_MS as a regular result.
  always_comb begin
    time_next = time_cnt;
    if (tick && (time_cnt < TO14)) time_next = time_cnt + 14'd1;
  end

  always_comb begin
    state_n    = state;
    load_delay = 1'b0;
    latch_hit  = 1'b0;
    latch_to   = 1'b0;
    if (!iEnable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (hit_edge) begin
            state_n    = ARMED;
            load_delay = 1'b1;
          end
        end
        ARMED: begin
          if (hit_edge) state_n = FALSE_START;
          else if (tick && (delay_cnt <= DLY_W'(1))) state_n = GO;
        end
        GO: begin
          if (hit_edge) begin
            state_n   = RESULT;
            latch_hit = 1'b1;
          end else if (time_next == TO14) begin
            state_n  = RESULT;
            latch_to = 1'b1;
          end
        end
        RESULT, FALSE_START: begin
          if (hit_edge) begin
            state_n    = ARMED;
            load_delay = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // Restart the prescaler on entry so the first tick lands one full ms later.
    clr = (state_n != state) && ((state_n == ARMED) || (state_n == GO));
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state     <= IDLE;
      oScreen   <= SCR_IDLE;
      hit_prev  <= 1'b1;
      lfsr      <= LFSR_SEED;
      delay_cnt <= '0;
      time_cnt  <= '0;
      oTimeMs   <= '0;
      oValid    <= 1'b0;
      oTimeout  <= 1'b0;
    end else begin
      state    <= state_n;
      oScreen  <= screen_of(state_n);
      hit_prev <= iHit;
      lfsr     <= lfsr_next(lfsr);
      oValid   <= latch_hit | latch_to;

      if (load_delay) begin
        delay_cnt <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[RAND_BITS-1:0]);
      end else if ((state == ARMED) && tick && (delay_cnt != '0)) begin
        delay_cnt <= delay_cnt - 1'b1;
      end

      if (clr && (state_n == GO)) time_cnt <= '0;
      else if (state == GO)       time_cnt <= time_next;

      if (latch_hit) begin
        oTimeMs  <= time_next;
        oTimeout <= 1'b0;
      end else if (latch_to) begin
        oTimeMs  <= TO14;
        oTimeout <= 1'b1;
      end
    end
  end

`ifdef REACT_CTRL_BEST_EN
  // Strictly-better times only; an equal time leaves the record untouched.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      oBestMs <= '0;
    end else if (iEnable && latch_hit && ((oBestMs == '0) || (time_next < oBestMs))) begin
      oBestMs <= time_next;
    end
  end
`else
  assign oBestMs = '0;
`endif

endmodule

// File: doc/react_controller.md
# react_controller

Sequencer for the reaction-time test mode. It runs each round: a random red-screen delay, then a green screen while it counts milliseconds until the player's key press. It also detects presses made too early, latches the measured time and tracks the best time. It sits below the main menu and is enabled while the menu selects react mode; its screen code and times drive the VGA renderer and the score display.

## Interface
- CLK_HZ, 50_000_000, clock frequency; must be a multiple of 1000
- MIN_DELAY_MS, 1000, minimum red-screen delay
- RAND_BITS, 12, LFSR bits added to the delay (delay range MIN..MIN+2^RAND_BITS-1 ms)
- TIMEOUT_MS, 9999, green-screen limit; must be below 2^14
- clk  input  1  system clock, all logic on rising edge
- iResetn  input  1  asynchronous, active-low reset
- iEnable  input  1  high while react mode is selected; level
- iHit  input  1  PS2 react key held; level, already synchronous to clk
- oScreen  output  3  0 idle, 1 red, 2 green, 3 result, 4 too soon
- oTimeMs  output  14  last latched reaction time in ms
- oValid  output  1  one-cycle pulse when oTimeMs is updated
- oTimeout  output  1  high while the last result was a timeout
- oBestMs  output  14  best non-timeout time; 0 means no result yet

## Operation
- Hit edge = iHit high and registered previous iHit low. The previous-value register resets to 1, so a key held through reset gives no edge.
- 16-bit Fibonacci LFSR (taps 16,14,13,11) free-runs every cycle, reset seed 16'hACE1.
- States and transitions:
  - IDLE: hit edge -> ARMED; load delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0].
  - ARMED: hit edge -> FALSE_START. Delay counter reaching 0 on a ms tick -> GO; clear time counter.
  - GO: time counter increments on each ms tick.
    - Hit edge -> RESULT; latch time, pulse oValid, clear oTimeout.
    - Counter reaches TIMEOUT_MS -> RESULT; latch TIMEOUT_MS, pulse oValid, set oTimeout.
  - RESULT, FALSE_START: hit edge -> ARMED with a fresh delay.
- iEnable low: next state IDLE from any state; highest priority after reset. Latched time and best time are kept.
- Simultaneous events, hit wins:
  - ARMED: hit edge on the expiry tick -> FALSE_START.
  - GO: hit edge on the timeout tick -> RESULT, non-timeout, time TIMEOUT_MS.
- Best time:
  - Updates on a non-timeout RESULT when oBestMs==0 or latched time < oBestMs.
  - Equal time: no change.
- Counters saturate and never wrap. The time counter stops at TIMEOUT_MS.
- Reset values:
  - state IDLE, oScreen 0
  - oTimeMs 0, oValid 0, oTimeout 0, oBestMs 0
  - counters 0, prescaler 0

## Timing
- ms tick: prescaler counts 0..CLK_HZ/1000-1 and ticks on the terminal count. It clears on entry to ARMED and GO, so the first tick comes exactly CLK_HZ/1000 cycles after entry.
- Every output is registered and changes on the clock edge at the state transition. oScreen follows the state with no extra latency.
- Latency:
  - Edge on iHit in GO to oValid/oTimeMs: 1 cycle after iHit is sampled high.
  - oValid is high for exactly one cycle, in the first cycle of RESULT.
- Recorded time is whole ms elapsed since green (floor). A hit before the first tick gives 0.

## Configuration
- REACT_CTRL_BEST_EN:
  - Defined: the best-time register and compare logic are compiled in, and oBestMs behaves as above.
  - Undefined: no register; oBestMs is constant 0.

## Structure
- Shared package react_pkg holds:
  - state encodings: IDLE, ARMED, GO, RESULT, FALSE_START
  - oScreen codes: SCR_IDLE..SCR_SOON
  - LFSR seed and tap constants
- One sub-module, ms_tick_gen, holds the prescaler, with inputs clk, iResetn, iClear and output oTick. Everything else stays in react_controller.

## Test plan
Simulation uses CLK_HZ=4000 (tick every 4 cycles), MIN_DELAY_MS=3, RAND_BITS=2, TIMEOUT_MS=20.
- Reset with iHit held high, then release -> oScreen=0, no transition, all outputs 0.
- Hit edge in IDLE, force lfsr[1:0]=2 -> red for 5 ms (20 cycles). Then green. Hit after 7 ticks -> oTimeMs=7, one-cycle oValid, oBestMs=7.
- Next round hit at 9 ms -> oTimeMs=9, oBestMs stays 7. Round at 4 ms -> oBestMs=4. Round at 4 ms -> unchanged.
- Hit edge during red -> oScreen=4, no oValid. Hit on the exact expiry-tick cycle -> oScreen=4.
- No hit in green -> at 20 ms oTimeMs=20, oTimeout=1, oBestMs unchanged. Hit on the timeout tick -> oTimeout=0, best updates to 20 only if no earlier best.
- iEnable drops mid-green -> IDLE next cycle, oTimeMs/oBestMs kept. iResetn asserted mid-round -> all outputs 0 immediately, without waiting for a clock edge. Build without REACT_CTRL_BEST_EN -> oBestMs=0 throughout.
